// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D cache memory arbiter: FSM states and owner encoding.
// CACHE_B (log2 line bytes) defaults to 4 when the build does not supply it.
`ifndef CACHE_B
`define CACHE_B 4
`endif

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_e;

    localparam logic OWNER_D = 1'b0;
    localparam logic OWNER_I = 1'b1;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// Beat counter for a line burst; clear wins over enable, 1-cycle update.
// No backpressure: advances whenever enabled.
module burst_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// I/D cache burst arbiter; MEM_ARBITER_ROUND_ROBIN_EN selects alternating tie-break.
// Grant 1 cycle after request in IDLE; bursts are never preempted, 1-cycle turnaround.
`ifndef CACHE_B
`define CACHE_B 4
`endif

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BURST_LEN  = 2**(`CACHE_B-2),
    parameter int BEAT_WIDTH = $clog2(BURST_LEN)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_req_i,
    input  logic                  d_req_i,
    input  logic                  i_write_en_i,
    input  logic                  d_write_en_i,
    input  logic [31:0]           i_addr_i,
    input  logic [31:0]           d_addr_i,
    input  logic [31:0]           i_wdata_i,
    input  logic [31:0]           d_wdata_i,
    output logic                  i_grant_o,
    output logic                  d_grant_o,
    output logic                  i_done_o,
    output logic                  d_done_o,
    output logic [BEAT_WIDTH-1:0] beat_o,
    output logic [31:0]           mem_addr_o,
    output logic                  mem_write_en_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    output logic [31:0]           rdata_o
);

    state_e state_q;
    state_e state_d;
    logic   pick_d;
    logic   last_beat;
    logic   cnt_clr;
    logic   cnt_en;

    // Offset bits below the line are replaced by the beat index.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_addr_i[`CACHE_B-1:0], d_addr_i[`CACHE_B-1:0]};

    assign last_beat = (beat_o == BEAT_WIDTH'(BURST_LEN-1));
    assign rdata_o   = mem_rdata_i;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_owner_q;
    logic last_owner_d;

    always_comb begin
        pick_d = d_req_i;
        if (i_req_i && d_req_i) begin
            pick_d = (last_owner_q == OWNER_I);
        end
        last_owner_d = last_owner_q;
        if ((state_q == IDLE) && (i_req_i || d_req_i)) begin
            last_owner_d = pick_d ? OWNER_D : OWNER_I;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_owner_q <= OWNER_D;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    assign pick_d = d_req_i;
`endif

    always_comb begin
        state_d        = state_q;
        i_grant_o      = 1'b0;
        d_grant_o      = 1'b0;
        i_done_o       = 1'b0;
        d_done_o       = 1'b0;
        mem_addr_o     = 32'h0;
        mem_write_en_o = 1'b0;
        mem_wdata_o    = 32'h0;
        cnt_clr        = 1'b1;
        cnt_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_i || d_req_i) begin
                    state_d = pick_d ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I: begin
                i_grant_o      = 1'b1;
                i_done_o       = last_beat && !rst_i;
                mem_addr_o     = {i_addr_i[31:`CACHE_B], beat_o, 2'b00};
                mem_write_en_o = i_write_en_i;
                mem_wdata_o    = i_wdata_i;
                cnt_clr        = last_beat;
                cnt_en         = !last_beat;
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            GRANT_D: begin
                d_grant_o      = 1'b1;
                d_done_o       = last_beat && !rst_i;
                mem_addr_o     = {d_addr_i[31:`CACHE_B], beat_o, 2'b00};
                mem_write_en_o = d_write_en_i;
                mem_wdata_o    = d_wdata_i;
                cnt_clr        = last_beat;
                cnt_en         = !last_beat;
                if (last_beat) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    burst_counter #(
        .WIDTH (BEAT_WIDTH)
    ) u_burst_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (beat_o)
    );

endmodule
